// File: rtl/vga_sync_gen.sv
// vga_sync_gen: 640x480@60 VGA timing (sync pins, blanking flag, pixel coordinates).
// Ports: clk, reset (async, active-low) -> hsync, vsync, video_on, p_tick, line_tick, frame_tick, pixel_x, pixel_y.
module vga_sync_gen #(
  parameter int CLK_DIV  = 2,
  parameter int HD       = 640,
  parameter int HF       = 16,
  parameter int HR       = 96,
  parameter int HB       = 48,
  parameter int VD       = 480,
  parameter int VF       = 10,
  parameter int VR       = 2,
  parameter int VB       = 33,
  parameter bit SYNC_ACT = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       p_tick,
  output logic       line_tick,
  output logic       frame_tick,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y
);

  localparam int H_TOT = HD + HF + HR + HB;
  localparam int V_TOT = VD + VF + VR + VB;

  localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOT - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOT - 1);
  localparam logic [9:0] H_DISP   = 10'(HD);
  localparam logic [9:0] V_DISP   = 10'(VD);
  localparam logic [9:0] H_SS     = 10'(HD + HF);
  localparam logic [9:0] H_SE     = 10'(HD + HF + HR - 1);
  localparam logic [9:0] V_SS     = 10'(VD + VF);
  localparam logic [9:0] V_SE     = 10'(VD + VF + VR - 1);

  if (H_TOT > 1024 || V_TOT > 1024 ||
      CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_cfg
    $error("vga_sync_gen: timing parameters out of range");
  end

  logic [3:0] div_q, div_d;
  logic [9:0] h_q, h_d;
  logic [9:0] v_q, v_d;
  logic       hs_q, hs_d;
  logic       vs_q, vs_d;
  logic       h_end, v_end;

  assign p_tick = (div_q == DIV_LAST);

  always_comb begin
    div_d = div_q + 4'd1;
    h_d   = h_q;
    v_d   = v_q;
    h_end = (h_q == H_LAST);
    v_end = (v_q == V_LAST);
    if (p_tick) begin
      div_d = '0;
      h_d   = h_end ? '0 : h_q + 10'd1;
      if (h_end) begin
        v_d = v_end ? '0 : v_q + 10'd1;
      end
    end
    // Sync is decoded from the next count so the registered pin
    // changes on the same edge as the coordinates.
    hs_d = (h_d >= H_SS && h_d <= H_SE) ? SYNC_ACT : ~SYNC_ACT;
    vs_d = (v_d >= V_SS && v_d <= V_SE) ? SYNC_ACT : ~SYNC_ACT;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q <= '0;
      h_q   <= '0;
      v_q   <= '0;
      hs_q  <= ~SYNC_ACT;
      vs_q  <= ~SYNC_ACT;
    end else begin
      div_q <= div_d;
      h_q   <= h_d;
      v_q   <= v_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
    end
  end

  assign hsync      = hs_q;
  assign vsync      = vs_q;
  assign pixel_x    = h_q;
  assign pixel_y    = v_q;
  assign video_on   = (h_q < H_DISP) && (v_q < V_DISP);
  assign line_tick  = p_tick & h_end;
  assign frame_tick = p_tick & h_end & v_end;

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: checks vga_sync_gen against a closed-form timing model.
// Three instances: full VGA (div 2), a shrunk frame (div 2), shrunk frame (div 1, active-high sync).
module tb_vga_sync_gen;

  localparam int SHD = 20, SHF = 4, SHR = 6, SHB = 5;
  localparam int SVD = 12, SVF = 3, SVR = 2, SVB = 4;
  localparam int SHT = SHD + SHF + SHR + SHB;
  localparam int SVT = SVD + SVF + SVR + SVB;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  logic       hs0, vs0, vo0, pt0, lt0, ft0;
  logic [9:0] x0, y0;
  logic       hs1, vs1, vo1, pt1, lt1, ft1;
  logic [9:0] x1, y1;
  logic       hs2, vs2, vo2, pt2, lt2, ft2;
  logic [9:0] x2, y2;
  logic [25:0] g0, g1, g2;
  logic [25:0] e0, e1, e2;

  assign g0 = {hs0, vs0, vo0, pt0, lt0, ft0, x0, y0};
  assign g1 = {hs1, vs1, vo1, pt1, lt1, ft1, x1, y1};
  assign g2 = {hs2, vs2, vo2, pt2, lt2, ft2, x2, y2};

  always #5 clk = ~clk;

  vga_sync_gen u0 (
    .clk(clk), .reset(rst_n), .hsync(hs0), .vsync(vs0),
    .video_on(vo0), .p_tick(pt0), .line_tick(lt0),
    .frame_tick(ft0), .pixel_x(x0), .pixel_y(y0)
  );

  vga_sync_gen #(
    .CLK_DIV(2), .HD(SHD), .HF(SHF), .HR(SHR), .HB(SHB),
    .VD(SVD), .VF(SVF), .VR(SVR), .VB(SVB), .SYNC_ACT(1'b0)
  ) u1 (
    .clk(clk), .reset(rst_n), .hsync(hs1), .vsync(vs1),
    .video_on(vo1), .p_tick(pt1), .line_tick(lt1),
    .frame_tick(ft1), .pixel_x(x1), .pixel_y(y1)
  );

  vga_sync_gen #(
    .CLK_DIV(1), .HD(SHD), .HF(SHF), .HR(SHR), .HB(SHB),
    .VD(SVD), .VF(SVF), .VR(SVR), .VB(SVB), .SYNC_ACT(1'b1)
  ) u2 (
    .clk(clk), .reset(rst_n), .hsync(hs2), .vsync(vs2),
    .video_on(vo2), .p_tick(pt2), .line_tick(lt2),
    .frame_tick(ft2), .pixel_x(x2), .pixel_y(y2)
  );

  // Closed form: after c clock edges since release, floor(c/d) pixels
  // have elapsed; position and flags follow from the frame geometry.
  function automatic logic [25:0] model(
    input int d, input int hd, input int hf, input int hr, input int hb,
    input int vd, input int vf, input int vr, input int vb,
    input bit act, input int c);
    int ht, vt, t, l, x, y;
    bit pt, hon, von;
    ht  = hd + hf + hr + hb;
    vt  = vd + vf + vr + vb;
    t   = c / d;
    l   = t % (ht * vt);
    x   = l % ht;
    y   = l / ht;
    pt  = ((c % d) == d - 1);
    hon = (x >= hd + hf) && (x < hd + hf + hr);
    von = (y >= vd + vf) && (y < vd + vf + vr);
    return {hon ? act : ~act, von ? act : ~act,
            (x < hd) && (y < vd), pt, pt && (x == ht - 1),
            pt && (l == ht * vt - 1), 10'(x), 10'(y)};
  endfunction

  function automatic void upd_exp(input int c);
    e0 = model(2, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, c);
    e1 = model(2, SHD, SHF, SHR, SHB, SVD, SVF, SVR, SVB, 1'b0, c);
    e2 = model(1, SHD, SHF, SHR, SHB, SVD, SVF, SVR, SVB, 1'b1, c);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    upd_exp(cyc);
  endtask

  task automatic release_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    upd_exp(0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    upd_exp(0);
    total++;
    if (g0 !== e0) begin
      bad++;
      $display("FAIL reset_u0 got=%h exp=%h", g0, e0);
    end
    total++;
    if (g2 !== e2) begin
      bad++;
      $display("FAIL reset_u2 got=%h exp=%h", g2, e2);
    end
    release_reset();
    for (int i = 0; i < 6; i++) begin
      step();
      total++;
      if (g0 !== e0 || g1 !== e1 || g2 !== e2) begin
        bad++;
        $display("FAIL release c=%0d got=%h/%h/%h exp=%h/%h/%h",
                 cyc, g0, g1, g2, e0, e1, e2);
      end
    end
  endtask

  task automatic test_line();
    int hs_cnt, lt_cnt, vo_x;
    hs_cnt = 0;
    lt_cnt = 0;
    vo_x = -1;
    rst_n = 1'b0;
    release_reset();
    for (int i = 0; i < 1600; i++) begin
      step();
      total++;
      if (g0 !== e0 || g1 !== e1 || g2 !== e2) begin
        bad++;
        $display("FAIL line c=%0d got=%h/%h/%h exp=%h/%h/%h",
                 cyc, g0, g1, g2, e0, e1, e2);
      end
      if (pt0 && hs0 == 1'b0) hs_cnt++;
      if (lt0) lt_cnt++;
      if (!vo0 && vo_x < 0) vo_x = int'(x0);
    end
    total++;
    if (hs_cnt != 96) begin
      bad++;
      $display("FAIL hsync_width got=%0d exp=96", hs_cnt);
    end
    total++;
    if (lt_cnt != 1) begin
      bad++;
      $display("FAIL line_ticks got=%0d exp=1", lt_cnt);
    end
    total++;
    if (vo_x != 640) begin
      bad++;
      $display("FAIL video_off_x got=%0d exp=640", vo_x);
    end
    total++;
    if (x0 !== 10'd0 || y0 !== 10'd1) begin
      bad++;
      $display("FAIL line_wrap got=(%0d,%0d) exp=(0,1)", x0, y0);
    end
  endtask

  task automatic test_frame();
    int last1, last2, per1, per2, n1, n2, seen;
    last1 = -1; last2 = -1; per1 = 0; per2 = 0;
    n1 = 0; n2 = 0; seen = 0;
    rst_n = 1'b0;
    release_reset();
    for (int i = 0; i < 2 * SHT * SVT * 2 + 10; i++) begin
      step();
      total++;
      if (g0 !== e0 || g1 !== e1 || g2 !== e2) begin
        bad++;
        $display("FAIL frame c=%0d got=%h/%h/%h exp=%h/%h/%h",
                 cyc, g0, g1, g2, e0, e1, e2);
      end
      if (pt1 && x1 == 10'd0 && y1 == 10'(SVD + 1)) seen++;
      if (ft1) begin
        if (last1 >= 0) per1 = cyc - last1;
        last1 = cyc;
        n1++;
      end
      if (ft2) begin
        if (last2 >= 0) per2 = cyc - last2;
        last2 = cyc;
        n2++;
      end
    end
    total++;
    if (n1 != 2 || per1 != SHT * SVT * 2) begin
      bad++;
      $display("FAIL frame_period_div2 got=%0d/%0d exp=2/%0d",
               n1, per1, SHT * SVT * 2);
    end
    total++;
    if (n2 != 4 || per2 != SHT * SVT) begin
      bad++;
      $display("FAIL frame_period_div1 got=%0d/%0d exp=4/%0d",
               n2, per2, SHT * SVT);
    end
    total++;
    if (seen != 2) begin
      bad++;
      $display("FAIL coord_once_per_frame got=%0d exp=2", seen);
    end
  endtask

  task automatic test_async_reset();
    int guard, pcnt;
    rst_n = 1'b0;
    release_reset();
    guard = 0;
    while (x0 != 10'd700 && guard < 2000) begin
      step();
      guard++;
    end
    total++;
    if (guard >= 2000 || hs0 !== 1'b0) begin
      bad++;
      $display("FAIL reach_x700 got=x%0d hs%0b exp=x700 hs0", x0, hs0);
    end
    #2;
    rst_n = 1'b0;
    #1;
    upd_exp(0);
    total++;
    if (g0 !== e0 || g1 !== e1 || g2 !== e2) begin
      bad++;
      $display("FAIL async_reset got=%h/%h/%h exp=%h/%h/%h",
               g0, g1, g2, e0, e1, e2);
    end
    release_reset();
    pcnt = 0;
    guard = 0;
    while (guard < 2000) begin
      step();
      guard++;
      total++;
      if (g0 !== e0) begin
        bad++;
        $display("FAIL post_reset c=%0d got=%h exp=%h", cyc, g0, e0);
      end
      if (hs0 == 1'b0) break;
      if (pt0) pcnt++;
    end
    total++;
    if (pcnt != 656) begin
      bad++;
      $display("FAIL hsync_after_reset got=%0d exp=656", pcnt);
    end
  endtask

  task automatic test_random_resets();
    int len;
    for (int k = 0; k < 5; k++) begin
      len = int'($urandom_range(40, 1500));
      for (int i = 0; i < len; i++) begin
        step();
        total++;
        if (g0 !== e0 || g1 !== e1 || g2 !== e2) begin
          bad++;
          $display("FAIL rand k=%0d c=%0d got=%h/%h/%h exp=%h/%h/%h",
                   k, cyc, g0, g1, g2, e0, e1, e2);
        end
      end
      #($urandom_range(1, 3));
      rst_n = 1'b0;
      #1;
      upd_exp(0);
      total++;
      if (g0 !== e0 || g1 !== e1 || g2 !== e2) begin
        bad++;
        $display("FAIL rand_reset k=%0d got=%h/%h/%h exp=%h/%h/%h",
                 k, g0, g1, g2, e0, e1, e2);
      end
      release_reset();
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_line();
    test_frame();
    test_async_reset();
    test_random_resets();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
